soc_addr_decoder: RTL and testbench

SOC_ADDR_DECODER -- requirements
Module: soc_addr_decoder

---
 rtl/soc_addr_decoder_pkg.sv | 71 +++++++
 rtl/soc_addr_rule_match.sv | 21 ++
 rtl/soc_addr_decoder.sv | 152 +++++++++++++++
 tb/tb_soc_addr_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_addr_decoder_pkg.sv
// Shared SoC address map: rule record, lock states and the reset-time rule table.
package soc_addr_decoder_pkg;

    localparam int unsigned SocAddrWidth = 64;
    localparam int unsigned SocNrRules   = 11;

    typedef struct packed {
        logic [63:0] base;
        logic [63:0] length;
        logic        valid;
    } rule_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam logic [63:0] DebugBase    = 64'h0000_0000;
    localparam logic [63:0] DebugLen     = 64'h0000_1000;
    localparam logic [63:0] DramBase     = 64'h8000_0000;
    localparam logic [63:0] DramLen      = 64'h4000_0000;
    localparam logic [63:0] RomBase      = 64'h0001_0000;
    localparam logic [63:0] RomLen       = 64'h0001_0000;
    localparam logic [63:0] ClintBase    = 64'h0200_0000;
    localparam logic [63:0] ClintLen     = 64'h0000_C000;
    localparam logic [63:0] PlicBase     = 64'h0C00_0000;
    localparam logic [63:0] PlicLen      = 64'h0400_0000;
    localparam logic [63:0] UartBase     = 64'h1000_0000;
    localparam logic [63:0] UartLen      = 64'h0000_1000;
    localparam logic [63:0] TimerBase    = 64'h1800_0000;
    localparam logic [63:0] TimerLen     = 64'h0000_1000;
    localparam logic [63:0] SpiBase      = 64'h2000_0000;
    localparam logic [63:0] SpiLen       = 64'h0080_0000;
    localparam logic [63:0] EthernetBase = 64'h3000_0000;
    localparam logic [63:0] EthernetLen  = 64'h0001_0000;
    localparam logic [63:0] GpioBase     = 64'h4000_0000;
    localparam logic [63:0] GpioLen      = 64'h0000_1000;
    localparam logic [63:0] ClicBase     = 64'h0800_0000;
    localparam logic [63:0] ClicLen      = 64'h0100_0000;

    function automatic rule_t soc_rule(input int unsigned idx);
        rule_t r;
        r = '0;
        case (idx)
            0:  r = '{base: DebugBase,    length: DebugLen,    valid: 1'b1};
            1:  r = '{base: DramBase,     length: DramLen,     valid: 1'b1};
            2:  r = '{base: RomBase,      length: RomLen,      valid: 1'b1};
            3:  r = '{base: ClintBase,    length: ClintLen,    valid: 1'b1};
            4:  r = '{base: PlicBase,     length: PlicLen,     valid: 1'b1};
            5:  r = '{base: UartBase,     length: UartLen,     valid: 1'b1};
            6:  r = '{base: TimerBase,    length: TimerLen,    valid: 1'b1};
            7:  r = '{base: SpiBase,      length: SpiLen,      valid: 1'b1};
            8:  r = '{base: EthernetBase, length: EthernetLen, valid: 1'b1};
            9:  r = '{base: GpioBase,     length: GpioLen,     valid: 1'b1};
            10: r = '{base: ClicBase,     length: ClicLen,     valid: 1'b0};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [SocNrRules*$bits(rule_t)-1:0] soc_rule_table();
        rule_t [SocNrRules-1:0] t;
        for (int unsigned i = 0; i < SocNrRules; i++) begin
            t[i] = soc_rule(i);
        end
        return t;
    endfunction

    localparam rule_t [SocNrRules-1:0] SocRuleInit = soc_rule_table();

endpackage

// File: rtl/soc_addr_rule_match.sv
// Single address-rule comparator: base <= addr < base + len, evaluated without wrap-around.
module soc_addr_rule_match
    import soc_addr_decoder_pkg::*;
#(
    parameter int unsigned AddrWidth = SocAddrWidth
) (
    input  logic [AddrWidth-1:0] i_addr,
    input  logic [AddrWidth-1:0] i_base,
    input  logic [AddrWidth-1:0] i_len,
    input  logic                 i_valid,
    output logic                 o_match
);

    logic [AddrWidth:0] w_diff;

    // The extra top bit is the borrow: set exactly when addr < base.
    assign w_diff  = {1'b0, i_addr} - {1'b0, i_base};
    assign o_match = i_valid && (i_len != '0) && !w_diff[AddrWidth]
                     && (w_diff < {1'b0, i_len});

endmodule

// File: rtl/soc_addr_decoder.sv
// Programmable SoC address decoder: lockable rule table, lowest-index-wins lookup,
// one-deep registered response with ready/valid handshake and saturating miss counter.
module soc_addr_decoder
    import soc_addr_decoder_pkg::*;
#(
    parameter int unsigned            NrRules    = SocNrRules,
    parameter int unsigned            AddrWidth  = SocAddrWidth,
    parameter int unsigned            DefaultIdx = 0,
    parameter rule_t [NrRules-1:0]    RuleInit   = SocRuleInit,
    localparam int unsigned           IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_we_i,
    input  logic [IdxW-1:0]      cfg_idx_i,
    input  logic [AddrWidth-1:0] cfg_base_i,
    input  logic [AddrWidth-1:0] cfg_len_i,
    input  logic                 cfg_en_i,
    input  logic                 cfg_lock_i,
    output logic                 cfg_err_o,
    output logic                 locked_o,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [AddrWidth-1:0] req_addr_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic                 rsp_hit_o,
    output logic [IdxW-1:0]      rsp_idx_o,
    output logic [31:0]          miss_cnt_o
);

    logic [AddrWidth-1:0] r_base  [NrRules];
    logic [AddrWidth-1:0] r_len   [NrRules];
    logic                 r_valid [NrRules];

    lock_state_e          r_state;
    logic                 r_locked;
    logic                 r_cfg_err;

    logic                 r_rsp_valid;
    logic                 r_rsp_hit;
    logic [IdxW-1:0]      r_rsp_idx;
    logic [31:0]          r_miss_cnt;

    logic                 w_idx_ok;
    logic                 w_wr_ok;
    logic                 w_wr_err;
    logic                 w_accept;
    logic [NrRules-1:0]   w_match;
    logic                 w_hit;
    logic [IdxW-1:0]      w_sel;

    assign w_idx_ok = 32'(cfg_idx_i) < NrRules;
    assign w_wr_ok  = cfg_we_i && (r_state == UNLOCKED) && w_idx_ok;
    assign w_wr_err = cfg_we_i && !w_wr_ok;

    assign req_ready_o = !r_rsp_valid || rsp_ready_i;
    assign w_accept    = req_valid_i && req_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                r_base[i]  <= AddrWidth'(RuleInit[i].base);
                r_len[i]   <= AddrWidth'(RuleInit[i].length);
                r_valid[i] <= RuleInit[i].valid;
            end
        end else if (w_wr_ok) begin
            r_base[cfg_idx_i]  <= cfg_base_i;
            r_len[cfg_idx_i]   <= cfg_len_i;
            r_valid[cfg_idx_i] <= cfg_en_i;
        end
    end

    // The write check above samples the pre-transition state, so write+lock commits the write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= UNLOCKED;
            r_locked  <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= w_wr_err;
            case (r_state)
                UNLOCKED: begin
                    if (cfg_lock_i) begin
                        r_state  <= LOCKED;
                        r_locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    r_state  <= LOCKED;
                    r_locked <= 1'b1;
                end
                default: begin
                    r_state  <= UNLOCKED;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NrRules; g++) begin : g_rule
        soc_addr_rule_match #(
            .AddrWidth(AddrWidth)
        ) u_match (
            .i_addr (req_addr_i),
            .i_base (r_base[g]),
            .i_len  (r_len[g]),
            .i_valid(r_valid[g]),
            .o_match(w_match[g])
        );
    end

    // Scan from the top down so the lowest matching index is the last to assign.
    always_comb begin
        w_hit = 1'b0;
        w_sel = IdxW'(DefaultIdx);
        for (int unsigned k = 0; k < NrRules; k++) begin
            if (w_match[NrRules-1-k]) begin
                w_hit = 1'b1;
                w_sel = IdxW'(NrRules-1-k);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_idx   <= IdxW'(DefaultIdx);
            r_miss_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_rsp_valid <= 1'b1;
                r_rsp_hit   <= w_hit;
                r_rsp_idx   <= w_sel;
                if (!w_hit && (r_miss_cnt != '1)) begin
                    r_miss_cnt <= r_miss_cnt + 32'd1;
                end
            end else if (rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cfg_err_o   = r_cfg_err;
    assign locked_o    = r_locked;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_hit_o   = r_rsp_hit;
    assign rsp_idx_o   = r_rsp_idx;
    assign miss_cnt_o  = r_miss_cnt;

endmodule

// File: tb/tb_soc_addr_decoder.sv
// Self-checking bench for soc_addr_decoder: directed and random lookups against an address-map model.
module tb_soc_addr_decoder;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_idx;
    logic [63:0] cfg_base;
    logic [63:0] cfg_len;
    logic        cfg_en;
    logic        cfg_lock;
    logic        cfg_err;
    logic        locked;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [3:0]  rsp_idx;
    logic [31:0] miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] mbase  [11];
    logic [63:0] mlen   [11];
    logic        mvalid [11];
    logic [31:0] mmiss;
    logic        mlocked;

    soc_addr_decoder dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_we_i   (cfg_we),
        .cfg_idx_i  (cfg_idx),
        .cfg_base_i (cfg_base),
        .cfg_len_i  (cfg_len),
        .cfg_en_i   (cfg_en),
        .cfg_lock_i (cfg_lock),
        .cfg_err_o  (cfg_err),
        .locked_o   (locked),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_addr_i (req_addr),
        .rsp_valid_o(rsp_valid),
        .rsp_ready_i(rsp_ready),
        .rsp_hit_o  (rsp_hit),
        .rsp_idx_o  (rsp_idx),
        .miss_cnt_o (miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        logic [63:0] b [11];
        logic [63:0] l [11];
        b = '{64'h0, 64'h8000_0000, 64'h1_0000, 64'h200_0000, 64'hC00_0000, 64'h1000_0000,
              64'h1800_0000, 64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h800_0000};
        l = '{64'h1000, 64'h4000_0000, 64'h1_0000, 64'hC000, 64'h400_0000, 64'h1000,
              64'h1000, 64'h80_0000, 64'h1_0000, 64'h1000, 64'h100_0000};
        for (int i = 0; i < 11; i++) begin
            mbase[i]  = b[i];
            mlen[i]   = l[i];
            mvalid[i] = (i != 10);
        end
        mmiss   = 0;
        mlocked = 1'b0;
    endtask

    function automatic void model_lookup(input logic [63:0] a, output logic h, output logic [3:0] ix);
        h  = 1'b0;
        ix = 4'd0;
        for (int i = 10; i >= 0; i--) begin
            if (mvalid[i] && mlen[i] != 0 && a >= mbase[i] && (a - mbase[i]) < mlen[i]) begin
                h  = 1'b1;
                ix = 4'(i);
            end
        end
    endfunction

    task automatic count_miss(input logic h);
        if (!h && mmiss != 32'hFFFF_FFFF) mmiss++;
    endtask

    task automatic lookup(input string tag, input logic [63:0] a);
        logic       eh;
        logic [3:0] ei;
        model_lookup(a, eh, ei);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        chk({tag, ".req_ready"}, req_ready, 1);
        step();
        req_valid = 1'b0;
        count_miss(eh);
        chk({tag, ".rsp_valid"}, rsp_valid, 1);
        chk({tag, ".hit"}, rsp_hit, eh);
        chk({tag, ".idx"}, rsp_idx, ei);
        chk({tag, ".miss_cnt"}, miss_cnt, mmiss);
    endtask

    task automatic cfg_write(input string tag, input logic [3:0] idx, input logic [63:0] b,
                             input logic [63:0] l, input logic en, input logic lk);
        logic err;
        err      = mlocked || (idx >= 4'd11);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_base = b;
        cfg_len  = l;
        cfg_en   = en;
        cfg_lock = lk;
        step();
        cfg_we   = 1'b0;
        cfg_lock = 1'b0;
        if (!err) begin
            mbase[idx]  = b;
            mlen[idx]   = l;
            mvalid[idx] = en;
        end
        if (lk) mlocked = 1'b1;
        chk({tag, ".err"}, cfg_err, err);
        chk({tag, ".locked"}, locked, mlocked);
        step();
        chk({tag, ".err_clear"}, cfg_err, 0);
    endtask

    initial begin
        logic        eh, eh2;
        logic [3:0]  ei, ei2;
        logic [63:0] a;
        int unsigned r;

        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_len = '0;
        cfg_en = 1'b0; cfg_lock = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        model_reset();
        step(); step(); step();
        chk("rst.rsp_valid", rsp_valid, 0);
        chk("rst.rsp_hit", rsp_hit, 0);
        chk("rst.rsp_idx", rsp_idx, 0);
        chk("rst.cfg_err", cfg_err, 0);
        chk("rst.locked", locked, 0);
        chk("rst.miss_cnt", miss_cnt, 0);
        rst = 1'b0;
        #1;
        chk("rst.req_ready", req_ready, 1);

        lookup("dram", 64'h8000_1000);
        lookup("hole", 64'h5000_0000);
        step();

        // Random lookups: mostly inside a randomly chosen rule, otherwise anywhere in 32-bit space.
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 10);
            if ($urandom_range(0, 9) < 7 && mlen[r] != 0)
                a = mbase[r] + ({$urandom(), $urandom()} % mlen[r]);
            else
                a = {32'h0, $urandom()};
            lookup("rand", a);
        end
        step();

        cfg_write("bad_idx11", 4'd11, 64'h0, 64'h1000, 1'b1, 1'b0);
        cfg_write("bad_idx15", 4'd15, 64'h0, 64'h1000, 1'b1, 1'b0);
        cfg_write("uart", 4'd5, 64'h1000_0000, 64'h1000, 1'b1, 1'b0);
        lookup("bnd_last", 64'h1000_0FFF);
        lookup("bnd_past", 64'h1000_1000);
        cfg_write("len0", 4'd6, 64'h1800_0000, 64'h0, 1'b1, 1'b0);
        lookup("len0_lo", 64'h1800_0000);
        lookup("len0_hi", 64'h1800_0010);
        cfg_write("dbg_off", 4'd0, 64'h0, 64'h1000, 1'b0, 1'b0);
        cfg_write("top", 4'd7, 64'hFFFF_FFFF_FFFF_F000, 64'h2000, 1'b1, 1'b0);
        lookup("nowrap0", 64'h0);
        lookup("top_end", 64'hFFFF_FFFF_FFFF_FFFF);

        cfg_write("ov3", 4'd3, 64'h3000_0000, 64'h1000, 1'b1, 1'b0);
        cfg_write("ov5", 4'd5, 64'h2FFF_0000, 64'h10_0000, 1'b1, 1'b0);
        lookup("overlap", 64'h3000_0000);
        step();

        // Lookup in the same cycle as a table write sees the old table.
        model_lookup(64'h5000_0010, eh, ei);
        cfg_we = 1'b1; cfg_idx = 4'd9; cfg_base = 64'h5000_0000; cfg_len = 64'h100; cfg_en = 1'b1;
        req_valid = 1'b1; req_addr = 64'h5000_0010; rsp_ready = 1'b1;
        step();
        cfg_we = 1'b0; req_valid = 1'b0;
        count_miss(eh);
        mbase[9] = 64'h5000_0000; mlen[9] = 64'h100; mvalid[9] = 1'b1;
        chk("wr_same.hit", rsp_hit, eh);
        chk("wr_same.idx", rsp_idx, ei);
        chk("wr_same.miss_cnt", miss_cnt, mmiss);
        lookup("wr_after", 64'h5000_0010);
        step();

        // Backpressure: first result held while a second request waits.
        model_lookup(64'h8000_0040, eh, ei);
        req_valid = 1'b1; req_addr = 64'h8000_0040; rsp_ready = 1'b0;
        step();
        count_miss(eh);
        model_lookup(64'h6000_0000, eh2, ei2);
        req_addr = 64'h6000_0000;
        for (int c = 0; c < 4; c++) begin
            chk("bp.req_ready", req_ready, 0);
            chk("bp.rsp_valid", rsp_valid, 1);
            chk("bp.hit", rsp_hit, eh);
            chk("bp.idx", rsp_idx, ei);
            chk("bp.miss_cnt", miss_cnt, mmiss);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.release_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        count_miss(eh2);
        chk("bp.second_hit", rsp_hit, eh2);
        chk("bp.second_idx", rsp_idx, ei2);
        chk("bp.second_miss", miss_cnt, mmiss);
        step();
        chk("bp.drained", rsp_valid, 0);

        for (int n = 0; n < 8; n++) lookup("b2b", {32'h0, $urandom()} | 64'h8000_0000);
        step();

        cfg_write("wr_lock", 4'd2, 64'h0600_0000, 64'h100, 1'b1, 1'b1);
        lookup("lock_applied", 64'h0600_0080);
        cfg_write("locked_wr", 4'd2, 64'h0700_0000, 64'h100, 1'b1, 1'b0);
        lookup("locked_new", 64'h0700_0000);
        lookup("locked_old", 64'h0600_0080);
        step();

        // Asynchronous reset while a response is pending.
        req_valid = 1'b1; req_addr = 64'h8000_0000; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk("arst.pending", rsp_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst.rsp_valid", rsp_valid, 0);
        chk("arst.locked", locked, 0);
        chk("arst.miss_cnt", miss_cnt, 0);
        step(); step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        model_reset();
        #1;
        chk("arst.req_ready", req_ready, 1);
        chk("arst.no_rsp", rsp_valid, 0);
        lookup("arst.debug", 64'h0);
        lookup("arst.gpio_hole", 64'h5000_0010);
        lookup("arst.eth", 64'h3000_0000);
        cfg_write("arst.unlocked_wr", 4'd4, 64'h0C00_0000, 64'h10, 1'b1, 1'b0);
        lookup("arst.plic_short", 64'h0C00_0010);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
